div_ctrl: RTL

//   Multi-cycle 32-bit radix-2 restoring divider with its sequencing FSM, serving the EX stage for DIV/DIVU.

---
 rtl/div_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; holds the pipeline via stallreq_o while working.
module div_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     dvd_q, dvd_d;
   logic [DATA_W-1:0]     dvs_q, dvs_d;
   logic [DATA_W-1:0]     rem_q, rem_d;
   logic [DATA_W-1:0]     quo_q, quo_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;

   logic [DATA_W:0]       minuend_s;
   logic [DATA_W-1:0]     quo_fix_s;
   logic [DATA_W-1:0]     rem_fix_s;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      minuend_s = {rem_q, dvd_q[DATA_W-1]};
      quo_fix_s = neg_quo_q ? (DATA_W'(0) - quo_q) : quo_q;
      rem_fix_s = neg_rem_q ? (DATA_W'(0) - rem_q) : rem_q;

      case (state_q)
         S_FREE: begin
            if (start_i && !annul_i) begin
               // Work on magnitudes; signs are reapplied when the result is loaded.
               neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
               neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
               dvd_d     = (signed_div_i && opdata1_i[DATA_W-1]) ? (DATA_W'(0) - opdata1_i) : opdata1_i;
               dvs_d     = (signed_div_i && opdata2_i[DATA_W-1]) ? (DATA_W'(0) - opdata2_i) : opdata2_i;
               rem_d     = '0;
               quo_d     = '0;
               cnt_d     = '0;
               state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d  = S_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q != CNT_W'(DATA_W)) begin
               if (minuend_s >= {1'b0, dvs_q}) begin
                  rem_d = DATA_W'(minuend_s - {1'b0, dvs_q});
                  quo_d = {quo_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d = minuend_s[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], 1'b0};
               end
               dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d  = S_END;
               result_d = {rem_fix_s, quo_fix_s};
               ready_d  = 1'b1;
            end
         end
         S_BYZERO: begin
            state_d  = annul_i ? S_FREE : S_END;
            result_d = '0;
            ready_d  = !annul_i;
         end
         S_END: begin
            if (annul_i || !start_i) begin
               state_d  = S_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            state_d  = S_FREE;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FREE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign stallreq_o = ((state_q == S_FREE) && start_i && !annul_i) ||
                       (state_q == S_ON) || (state_q == S_BYZERO);

endmodule
